seq_always_lane_distributor: RTL and testbench

Sequential counterpart to the combinational multiplexer fixtures in the elaboration test suite. It takes one valid/ready input stream and distributes each accepted word into one of LANES one-entry output slots. The destination is chosen either round-robin or by an explicit lane select. The block exercises `always_ff` elaboration paths: register inference, enables, case-driven writes, a two-state FSM and a saturating counter.

---
 rtl/seq_always_pkg.sv | 27 ++
 rtl/seq_always_lane_slot.sv | 37 +++
 rtl/seq_always_lane_distributor.sv | 113 +++++++++++
 tb/tb_seq_always_lane_distributor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_always_pkg.sv
// Shared types and constants for the lane distributor.
package seq_always_pkg;

    // Distributor control states.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } dist_state_t;

    // Width of the accepted-word counter.
    localparam int COUNT_W = 8;

    // Counter saturation value (all ones).
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Round-robin successor. Lane counts are powers of two, so the
    // natural wrap of a $clog2(lanes)-bit pointer is the modulo.
    function automatic logic [7:0] rr_next(input logic [7:0] ptr, input int lanes);
        logic [7:0] nxt;
        nxt = ptr + 8'd1;
        if (int'(nxt) >= lanes) begin
            nxt = 8'd0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/seq_always_lane_slot.sv
// One-entry output slot. A load in the same cycle as a drain wins, so the
// slot stays occupied with the new word. Data is held after a drain.
module seq_always_lane_slot
    import seq_always_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Occupancy flag: load has priority over drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain && valid) begin
            valid <= 1'b0;
        end
    end

    // Payload register: only written on load, never cleared by a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/seq_always_lane_distributor.sv
// Distributes a valid/ready input stream into LANES one-entry output slots,
// either round-robin or by explicit lane select, with a drain-all flush.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | accepting words; flush request moves to FLUSH (no accept then)
//   FLUSH | input blocked; lanes drain; all empty -> RUN, rr_ptr=0, pulse
module seq_always_lane_distributor
    import seq_always_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [$clog2(LANES)-1:0]  in_sel,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [LANES-1:0]          out_valid,
    input  logic [LANES-1:0]          out_ready,
    output logic [LANES*WIDTH-1:0]    out_data,
    output logic [COUNT_W-1:0]        accept_count
);

    localparam int SEL_W = $clog2(LANES);

    dist_state_t      state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] target;
    logic             accept;
    logic             target_free;
    logic             all_empty;
    logic [LANES-1:0] load;

    // Destination lane: round-robin pointer or the explicit select.
    assign target = mode ? in_sel : rr_ptr;

    // The target lane can take a word if it is empty or draining this cycle.
    assign target_free = !out_valid[target] || out_ready[target];

    assign in_ready  = (state == RUN) && !flush && target_free;
    assign accept    = in_valid && in_ready;
    assign all_empty = (out_valid == '0);

    // One-hot load strobe for the target slot.
    always_comb begin
        load = '0;
        if (accept) begin
            load[target] = 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            seq_always_lane_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (load[g]),
                .drain     (out_ready[g]),
                .load_data (in_data),
                .valid     (out_valid[g]),
                .data      (out_data[g*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // Control FSM with registered rr_ptr and flush_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                    end else if (accept && !mode) begin
                        rr_ptr <= SEL_W'(rr_next(8'(rr_ptr), LANES));
                    end
                end
                FLUSH: begin
                    if (all_empty) begin
                        state      <= RUN;
                        rr_ptr     <= '0;
                        flush_done <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Saturating accepted-word counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_count <= '0;
        end else if (accept && (accept_count != COUNT_MAX)) begin
            accept_count <= accept_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_always_lane_distributor.sv
// Self-checking bench for seq_always_lane_distributor (WIDTH=4, LANES=4).
module tb_seq_always_lane_distributor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  in_sel = 2'd0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'd0;
    logic [15:0] out_data;
    logic [7:0]  accept_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] lane;
        logic [3:0] data;
    } sb_t;

    sb_t sb[$];

    // Reference model state
    logic       m_state;
    logic [1:0] m_rr;
    logic [3:0] m_valid;
    int         m_count;

    seq_always_lane_distributor #(.WIDTH(4), .LANES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .flush        (flush),
        .flush_done   (flush_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    function automatic sb_t sb_pop();
        sb_t e;
        if (sb.size() == 0) begin
            e.lane = 2'd0;
            e.data = 4'bxxxx;
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    // Advance one clock; update the model and push accepted words.
    task automatic tick();
        logic [1:0] t;
        logic       rdy;
        logic       acc;
        logic [3:0] prev_valid;
        t = mode ? in_sel : m_rr;
        rdy = (m_state == 1'b0) && !flush && (!m_valid[t] || out_ready[t]);
        acc = in_valid && rdy;
        prev_valid = m_valid;
        @(posedge clk);
        if (rst) begin
            m_state = 1'b0;
            m_rr    = 2'd0;
            m_valid = 4'd0;
            m_count = 0;
            sb.delete();
        end else begin
            m_valid = m_valid & ~out_ready;
            if (acc) begin
                m_valid[t] = 1'b1;
                sb.push_back('{lane: t, data: in_data});
                if (!mode) m_rr = m_rr + 2'd1;
                if (m_count < 255) m_count++;
            end
            if (m_state == 1'b0) begin
                if (flush) m_state = 1'b1;
            end else if (prev_valid == 4'd0) begin
                m_state = 1'b0;
                m_rr    = 2'd0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
        n_cmp++; if (accept_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", accept_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    endtask

    task automatic test_round_robin();
        sb_t e;
        mode = 1'b0;
        out_ready = 4'b0000;
        for (int w = 1; w <= 4; w++) begin
            in_valid = 1'b1;
            in_data  = 4'(w);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready_%0d: got %b want 1", w, in_ready); end
            tick();
        end
        in_data = 4'h5;
        #1;
        n_cmp++; if (out_valid !== 4'b1111) begin n_err++; $display("FAIL rr_full: got %b want 1111", out_valid); end
        for (int k = 0; k < 4; k++) begin
            e = sb_pop();
            n_cmp++;
            if (e.lane !== 2'(k) || out_data[k*4 +: 4] !== e.data || e.data !== 4'(k + 1)) begin
                n_err++;
                $display("FAIL rr_lane%0d: got %h want %h", k, out_data[k*4 +: 4], 4'(k + 1));
            end
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rr_stall: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rr_stall2: got %b want 0", in_ready); end
        out_ready = 4'b0001;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rr_unstall: got %b want 1", in_ready); end
        tick();
        out_ready = 4'b0000;
        in_valid  = 1'b0;
        #1;
        e = sb_pop();
        n_cmp++; if (out_valid !== 4'b1111) begin n_err++; $display("FAIL rr_refill: got %b want 1111", out_valid); end
        n_cmp++; if (out_data[3:0] !== e.data || e.data !== 4'h5) begin n_err++; $display("FAIL rr_lane0_5: got %h want 5", out_data[3:0]); end
        n_cmp++; if (accept_count !== 8'd5) begin n_err++; $display("FAIL rr_count: got %0d want 5", accept_count); end
    endtask

    task automatic test_directed_load_wins();
        sb_t e;
        out_ready = 4'b1111;
        in_valid  = 1'b0;
        tick();
        out_ready = 4'b0000;
        mode      = 1'b1;
        in_sel    = 2'd2;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_ready: got %b want 1", in_ready); end
        tick();
        e = sb_pop();
        n_cmp++; if (out_data[11:8] !== e.data || e.data !== 4'hA) begin n_err++; $display("FAIL dir_lane2_A: got %h want a", out_data[11:8]); end
        out_ready = 4'b0100;
        in_data   = 4'hB;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_ready_drain: got %b want 1", in_ready); end
        tick();
        out_ready = 4'b0000;
        in_valid  = 1'b0;
        #1;
        e = sb_pop();
        n_cmp++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL dir_load_wins_valid: got %b want 0100", out_valid); end
        n_cmp++; if (out_data[11:8] !== e.data || e.data !== 4'hB) begin n_err++; $display("FAIL dir_load_wins_data: got %h want b", out_data[11:8]); end
        mode     = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hC;
        tick();
        in_valid = 1'b0;
        #1;
        e = sb_pop();
        n_cmp++; if (out_valid !== 4'b0110) begin n_err++; $display("FAIL dir_rr_kept: got %b want 0110", out_valid); end
        n_cmp++; if (out_data[7:4] !== e.data || e.data !== 4'hC) begin n_err++; $display("FAIL dir_rr_lane1: got %h want c", out_data[7:4]); end
    endtask

    task automatic test_flush();
        sb_t e;
        out_ready = 4'b1111;
        in_valid  = 1'b0;
        tick();
        out_ready = 4'b0000;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hD;
        tick();
        e = sb_pop();
        n_cmp++; if (out_data[11:8] !== e.data || e.data !== 4'hD) begin n_err++; $display("FAIL fl_setup_D: got %h want d", out_data[11:8]); end
        mode      = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'h6;
        out_ready = 4'b0100;
        tick();
        e = sb_pop();
        n_cmp++; if (out_data[7:4] !== e.data || e.data !== 4'h6) begin n_err++; $display("FAIL fl_setup_6: got %h want 6", out_data[7:4]); end
        in_sel    = 2'd3;
        in_data   = 4'h7;
        out_ready = 4'b0000;
        tick();
        e = sb_pop();
        n_cmp++; if (out_data[15:12] !== e.data || e.data !== 4'h7) begin n_err++; $display("FAIL fl_setup_7: got %h want 7", out_data[15:12]); end
        in_valid = 1'b0;
        mode     = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 4'b1010) begin n_err++; $display("FAIL fl_setup_valid: got %b want 1010", out_valid); end
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_req_ready: got %b want 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_state_ready: got %b want 0", in_ready); end
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b1000;
        #1;
        n_cmp++; if (out_valid !== 4'b1000) begin n_err++; $display("FAIL fl_drain1: got %b want 1000", out_valid); end
        n_cmp++; if (in_ready !== 1'b0 || flush_done !== 1'b0) begin n_err++; $display("FAIL fl_mid: got ready=%b done=%b want 0 0", in_ready, flush_done); end
        tick();
        out_ready = 4'b0000;
        #1;
        n_cmp++; if (out_valid !== 4'b0000 || flush_done !== 1'b0) begin n_err++; $display("FAIL fl_drain3: got valid=%b done=%b want 0000 0", out_valid, flush_done); end
        tick();
        in_data = 4'h8;
        #1;
        n_cmp++; if (flush_done !== 1'b1) begin n_err++; $display("FAIL fl_done: got %b want 1", flush_done); end
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL fl_no_accept: got %b want 0000", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_run_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        e = sb_pop();
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL fl_done_pulse: got %b want 0", flush_done); end
        n_cmp++; if (out_valid !== 4'b0001 || out_data[3:0] !== e.data || e.data !== 4'h8) begin n_err++; $display("FAIL fl_rr_reset: got valid=%b data=%h want 0001 8", out_valid, out_data[3:0]); end
    endtask

    task automatic test_flush_empty_input();
        out_ready = 4'b1111;
        in_valid  = 1'b0;
        tick();
        out_ready = 4'b0000;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h9;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fe_ready: got %b want 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 4'b0000 || flush_done !== 1'b0) begin n_err++; $display("FAIL fe_n1: got valid=%b done=%b want 0000 0", out_valid, flush_done); end
        tick();
        n_cmp++; if (flush_done !== 1'b1) begin n_err++; $display("FAIL fe_done: got %b want 1", flush_done); end
        n_cmp++; if (accept_count !== 8'd12 || m_count != 12) begin n_err++; $display("FAIL fe_count: got %0d want 12", accept_count); end
        tick();
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL fe_done_end: got %b want 0", flush_done); end
    endtask

    task automatic test_saturation();
        sb_t e;
        mode      = 1'b0;
        out_ready = 4'b1111;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            tick();
            e = sb_pop();
            n_cmp++;
            if (out_valid[e.lane] !== 1'b1 || out_data[e.lane*4 +: 4] !== e.data || e.data !== 4'(i)) begin
                n_err++;
                $display("FAIL sat_word%0d: got %h want %h", i, out_data[e.lane*4 +: 4], 4'(i));
            end
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (accept_count !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", accept_count); end
        tick();
        tick();
        n_cmp++; if (accept_count !== 8'd255 || out_valid !== 4'b0000) begin n_err++; $display("FAIL sat_hold: got %0d valid=%b want 255 0000", accept_count, out_valid); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sat_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 4'h3;
        tick();
        tick();
        n_cmp++; if (out_valid !== 4'b0011) begin n_err++; $display("FAIL rm_pre: got %b want 0011", out_valid); end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 4'b0000 || out_data !== 16'h0000) begin n_err++; $display("FAIL rm_slots: got %b %h want 0000 0000", out_valid, out_data); end
        n_cmp++; if (accept_count !== 8'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ctrl: got count=%0d ready=%b want 0 1", accept_count, in_ready); end
    endtask

    initial begin
        m_state = 1'b0;
        m_rr    = 2'd0;
        m_valid = 4'd0;
        m_count = 0;
        test_reset();
        test_round_robin();
        test_directed_load_wins();
        test_flush();
        test_flush_empty_input();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
